result_uart_sequencer: RTL and testbench
========================================

Name: result_uart_sequencer

Overview:
Sits between the program-execution block and the UART transmitter. It captures a multi-byte result word when the program stops running. It then serialises the word MSB-byte-first onto the UART transmit handshake, one byte per UART frame, and reports completion. It replaces the ad-hoc single-byte transmit logic at the top level and sends each result exactly once per run.

Parameters:
RESULT_BYTES, 4, number of result bytes captured and sent (1..16)
BUSY_TIMEOUT, 1023, max cycles to wait for uart_busy to rise after transmit is raised; on expiry, retry
MAX_RETRIES, 3, retries per byte before abort (error flagged)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
prog_running  in  1  high while the program block is executing
result  in  8*RESULT_BYTES  program result; sampled only at capture
uart_busy  in  1  UART is_transmitting
uart_transmit  out  1  UART transmit request
uart_tx_byte  out  8  byte presented to UART
seq_busy  out  1  high from capture until DONE/ERROR
seq_done  out  1  high after a successful send; cleared on next capture
seq_error  out  1  high after retries are exhausted; cleared on next capture

Behaviour:
- Reset (clk edge with reset=1) forces state ARMED, all outputs 0, and clears the shift register, byte counter, timeout counter and retry counter. The clock is clk.
- Trigger: in ARMED, the first cycle with prog_running=0 triggers a capture, including the first cycle after reset.
- Re-arm: after DONE or ERROR, prog_running must be seen 1 (go to ARMED), then 0 again, to trigger a new capture.
- States: ARMED -> LOAD -> REQ -> WAIT_HI -> WAIT_LO -> (REQ | DONE); REQ/WAIT_HI -> ERROR on abort.
- LOAD (1 cycle):
  - result -> shift register; byte count = RESULT_BYTES; seq_busy=1; seq_done=0; seq_error=0.
  - Later changes on result are ignored.
- REQ (1 cycle):
  - uart_tx_byte = shift[MSB byte]; uart_transmit=1; timeout counter=0.
  - Go to WAIT_HI.
- WAIT_HI:
  - Hold uart_transmit=1 and uart_tx_byte stable.
  - On uart_busy=1: drop uart_transmit the next cycle and go to WAIT_LO.
  - If the timeout counter reaches BUSY_TIMEOUT: drop uart_transmit for 1 cycle, increment retry, go to REQ.
  - If retry would exceed MAX_RETRIES: go to ERROR.
- WAIT_LO:
  - uart_tx_byte stays stable until uart_busy=0.
  - On uart_busy=0: shift left 8 bits, decrement count, reset retry.
  - Go to REQ if count>0, otherwise DONE.
- DONE: seq_busy=0; seq_done=1. uart_transmit=0.
- ERROR: seq_busy=0; seq_error=1; uart_transmit=0.
- Both DONE and ERROR wait for prog_running=1, then go to ARMED (done/error stay high).
- prog_running rising mid-send: ignored; the current result finishes. A trigger is only recognised in ARMED.
- uart_busy already 1 on entry to REQ (UART still draining): stay in REQ without asserting transmit until uart_busy=0.
- Reset mid-send: uart_transmit drops in the same reset cycle. A partially sent result is abandoned, not resumed.
- Counters: timeout counter width = clog2(BUSY_TIMEOUT+1); it saturates and does not wrap.
- Latency: trigger cycle -> uart_transmit high = 2 cycles (ARMED->LOAD->REQ).

Optional Feature:
- Macro: RESULT_UART_HEX_ASCII_EN.
- Defined:
  - Each result byte is sent as two uppercase ASCII hex characters, high nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
  - After the last byte, 0x0D then 0x0A are sent.
  - Frames per capture = 2*RESULT_BYTES+2.
  - The nibble/suffix phase is part of the same counter/state flow; the retry/timeout rules apply per character.
- Undefined: raw binary, RESULT_BYTES frames, no suffix.

Test Plan:
- Reset release with prog_running=0, result=0x11223344, UART model (busy 1 cycle after transmit, 10 cycles long) -> bytes 0x11,0x22,0x33,0x44 in order. seq_done=1 after the last busy fall, and no further uart_transmit.
- prog_running=1 for 50 cycles, then 0 with result=0xDEADBEEF; change result 1 cycle after capture -> exactly 0xDE,0xAD,0xBE,0xEF sent once. A second 0->1->0 pulse re-sends the new value.
- UART model never raises busy, BUSY_TIMEOUT=15, MAX_RETRIES=3 -> 4 transmit attempts, each held 16 cycles, then seq_error=1, seq_busy=0, uart_transmit=0.
- Busy raised only on the 2nd attempt of byte 0 -> all 4 bytes sent, seq_error=0.
- Assert reset during byte 2's WAIT_LO -> uart_transmit=0 and seq_busy=0 next cycle; after release with prog_running=0, the full 4-byte sequence restarts.
- RESULT_UART_HEX_ASCII_EN defined, result=0x0A1B2C3D -> frames 0x30,0x41,0x31,0x42,0x32,0x43,0x33,0x44,0x0D,0x0A, then seq_done=1.

Source files
------------

// File: rtl/result_uart_sequencer.sv
// Captures the result word when the program stops and sends it MSB byte first over the UART handshake, one frame at a time.
// Transmit rises 2 cycles after the trigger; each frame waits on uart_busy. Optional RESULT_UART_HEX_ASCII_EN sends ASCII hex plus CR LF.
module result_uart_sequencer #(
  parameter int RESULT_BYTES = 4,
  parameter int BUSY_TIMEOUT = 1023,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      prog_running,
  input  logic [8*RESULT_BYTES-1:0] result,
  input  logic                      uart_busy,
  output logic                      uart_transmit,
  output logic [7:0]                uart_tx_byte,
  output logic                      seq_busy,
  output logic                      seq_done,
  output logic                      seq_error
);

`ifdef RESULT_UART_HEX_ASCII_EN
  localparam int FRAMES = 2 * RESULT_BYTES + 2;
`else
  localparam int FRAMES = RESULT_BYTES;
`endif
  localparam int DW    = 8 * RESULT_BYTES;
  localparam int CNT_W = $clog2(FRAMES + 1);
  localparam int TO_W  = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam int RT_W  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] FRAMES_C = CNT_W'(FRAMES);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(BUSY_TIMEOUT);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_ARMED, S_LOAD, S_REQ, S_WAIT_HI, S_WAIT_LO, S_DONE, S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_to;
  logic [RT_W-1:0]  r_retry;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_tx;
  logic             w_sending;
  logic [7:0]       w_byte;
  logic [7:0]       w_char;

  assign w_byte = r_shift[DW-1 -: 8];

`ifdef RESULT_UART_HEX_ASCII_EN
  logic       r_nib;
  logic [3:0] w_nib;
  assign w_nib = r_nib ? w_byte[3:0] : w_byte[7:4];

  // The last two frames of a capture are the CR LF suffix.
  always_comb begin
    w_char = (w_nib < 4'd10) ? {4'h3, w_nib} : (8'h37 + {4'h0, w_nib});
    if (r_cnt == CNT_W'(2))      w_char = 8'h0D;
    else if (r_cnt == CNT_W'(1)) w_char = 8'h0A;
  end
`else
  assign w_char = w_byte;
`endif

  always_comb begin
    w_next = r_state;
    w_tx   = 1'b0;
    case (r_state)
      S_ARMED:   if (!prog_running) w_next = S_LOAD;
      S_LOAD:    w_next = S_REQ;
      S_REQ: begin
        // A still-draining UART holds us here without requesting.
        if (!uart_busy) begin
          w_tx   = 1'b1;
          w_next = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (uart_busy) begin
          w_tx   = 1'b1;
          w_next = S_WAIT_LO;
        end else if (r_to != TO_MAX) begin
          w_tx = 1'b1;
        end else begin
          w_next = (r_retry == RT_MAX) ? S_ERROR : S_REQ;
        end
      end
      S_WAIT_LO: if (!uart_busy) w_next = (r_cnt == CNT_W'(1)) ? S_DONE : S_REQ;
      S_DONE, S_ERROR: if (prog_running) w_next = S_ARMED;
      default:   w_next = S_ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_ARMED;
      r_shift <= '0;
      r_cnt   <= '0;
      r_to    <= '0;
      r_retry <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef RESULT_UART_HEX_ASCII_EN
      r_nib   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_ARMED: begin
          if (!prog_running) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_shift <= result;
          r_cnt   <= FRAMES_C;
          r_retry <= '0;
`ifdef RESULT_UART_HEX_ASCII_EN
          r_nib   <= 1'b0;
`endif
        end
        S_REQ: r_to <= '0;
        S_WAIT_HI: begin
          if (!uart_busy) begin
            if (r_to != TO_MAX) begin
              r_to <= r_to + TO_W'(1);
            end else if (r_retry == RT_MAX) begin
              r_busy <= 1'b0;
              r_err  <= 1'b1;
            end else begin
              r_retry <= r_retry + RT_W'(1);
            end
          end
        end
        S_WAIT_LO: begin
          if (!uart_busy) begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_retry <= '0;
`ifdef RESULT_UART_HEX_ASCII_EN
            if (r_cnt > CNT_W'(2)) begin
              r_nib <= ~r_nib;
              if (r_nib) r_shift <= r_shift << 8;
            end
`else
            r_shift <= r_shift << 8;
`endif
            if (r_cnt == CNT_W'(1)) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_sending     = (r_state == S_REQ) || (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
  assign uart_transmit = w_tx & ~reset;
  assign uart_tx_byte  = w_sending ? w_char : 8'h00;
  assign seq_busy      = r_busy;
  assign seq_done      = r_done;
  assign seq_error     = r_err;

endmodule

// File: tb/tb_result_uart_sequencer.sv
// Directed bench for result_uart_sequencer with a UART model (busy one cycle after a transmit rise, 10 cycles long).
module tb_result_uart_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_running = 1'b0;
  logic [31:0] result = 32'h11223344;
  logic        uart_busy = 1'b0;
  logic        uart_transmit;
  logic [7:0]  uart_tx_byte;
  logic        seq_busy, seq_done, seq_error;

  int total = 0;
  int bad = 0;

  logic [7:0] rx_q[$];
  int         hold_q[$];
  int         att_cnt = 0;
  int         ign_until = 0;
  int         m_left = 0;
  int         m_hold = 0;
  logic       m_prev_tx = 1'b0;

  logic [7:0] exp_f [0:9];
  int         exp_n;

  result_uart_sequencer #(.RESULT_BYTES(4), .BUSY_TIMEOUT(15), .MAX_RETRIES(3)) dut (
    .clk(clk), .reset(reset), .prog_running(prog_running), .result(result),
    .uart_busy(uart_busy), .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  // UART model: accepts a frame on a transmit rise unless told to ignore that attempt.
  always @(posedge clk) begin
    m_prev_tx <= uart_transmit;
    if (uart_transmit) m_hold <= m_hold + 1;
    else if (m_hold > 0) begin
      hold_q.push_back(m_hold);
      m_hold <= 0;
    end
    if (m_left > 0) begin
      m_left    <= m_left - 1;
      uart_busy <= (m_left > 1);
    end else if (uart_transmit && !m_prev_tx) begin
      att_cnt <= att_cnt + 1;
      if (att_cnt >= ign_until) begin
        m_left    <= 10;
        uart_busy <= 1'b1;
        rx_q.push_back(uart_tx_byte);
      end
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic make_exp(input logic [31:0] r);
    logic [7:0] b;
    exp_n = 0;
    for (int i = 3; i >= 0; i--) begin
      b = r[8*i +: 8];
`ifdef RESULT_UART_HEX_ASCII_EN
      exp_f[exp_n]     = hexc(b[7:4]);
      exp_f[exp_n + 1] = hexc(b[3:0]);
      exp_n += 2;
`else
      exp_f[exp_n] = b;
      exp_n += 1;
`endif
    end
`ifdef RESULT_UART_HEX_ASCII_EN
    exp_f[8] = 8'h0D;
    exp_f[9] = 8'h0A;
    exp_n = 10;
`endif
  endtask

  // Leaves DONE/ERROR via prog_running=1, then triggers; returns in the LOAD cycle.
  task automatic pulse_run();
    @(posedge clk); #1 prog_running = 1'b1;
    @(posedge clk); #1 prog_running = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (uart_transmit !== 1'b0) begin bad++; $display("FAIL reset_tx got=%b want=0", uart_transmit); end
    total++; if (uart_tx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h want=00", uart_tx_byte); end
    total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", seq_busy); end
    total++; if (seq_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", seq_done); end
    total++; if (seq_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", seq_error); end
    make_exp(32'h11223344);
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (seq_busy !== 1'b1) begin bad++; $display("FAIL load_busy got=%b want=1", seq_busy); end
    total++; if (uart_transmit !== 1'b0) begin bad++; $display("FAIL load_tx got=%b want=0", uart_transmit); end
    @(posedge clk); #1;
    total++; if (uart_transmit !== 1'b1) begin bad++; $display("FAIL latency_tx got=%b want=1", uart_transmit); end
    total++; if (uart_tx_byte !== exp_f[0]) begin bad++; $display("FAIL first_byte got=%h want=%h", uart_tx_byte, exp_f[0]); end
  endtask

  task automatic test_basic();
    int n, att0;
    logic [7:0] got;
    n = 0;
    while (seq_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++; if (seq_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", seq_done); end
    total++; if (rx_q.size() != exp_n) begin bad++; $display("FAIL basic_count got=%0d want=%0d", rx_q.size(), exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      total++; if (got !== exp_f[i]) begin bad++; $display("FAIL basic_frame%0d got=%h want=%h", i, got, exp_f[i]); end
    end
    total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", seq_busy); end
    att0 = att_cnt;
    repeat (30) @(posedge clk);
    #1;
    total++; if (att_cnt != att0) begin bad++; $display("FAIL basic_extra_tx got=%0d want=%0d", att_cnt, att0); end
    total++; if (seq_done !== 1'b1) begin bad++; $display("FAIL basic_done_hold got=%b want=1", seq_done); end
  endtask

  task automatic test_rerun();
    int n, base;
    logic [7:0] got;
    @(posedge clk); #1 prog_running = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    total++; if (seq_done !== 1'b1) begin bad++; $display("FAIL armed_done got=%b want=1", seq_done); end
    base = rx_q.size();
    result = 32'hDEADBEEF;
    prog_running = 1'b0;
    n = 0;
    while (uart_transmit !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    result = 32'hCAFEF00D;
    n = 0;
    while (seq_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    make_exp(32'hDEADBEEF);
    total++; if (rx_q.size() - base != exp_n) begin bad++; $display("FAIL rerun_count got=%0d want=%0d", rx_q.size() - base, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      total++; if (got !== exp_f[i]) begin bad++; $display("FAIL rerun_frame%0d got=%h want=%h", i, got, exp_f[i]); end
    end
    base = rx_q.size();
    pulse_run();
    n = 0;
    while (seq_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    make_exp(32'hCAFEF00D);
    total++; if (rx_q.size() - base != exp_n) begin bad++; $display("FAIL resend_count got=%0d want=%0d", rx_q.size() - base, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      total++; if (got !== exp_f[i]) begin bad++; $display("FAIL resend_frame%0d got=%h want=%h", i, got, exp_f[i]); end
    end
  endtask

  task automatic test_timeout();
    int n, hb, rb, h;
    ign_until = att_cnt + 1000;
    hb = hold_q.size();
    rb = rx_q.size();
    result = 32'h55667788;
    pulse_run();
    n = 0;
    while (seq_error !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++; if (seq_error !== 1'b1) begin bad++; $display("FAIL timeout_error got=%b want=1", seq_error); end
    total++; if (hold_q.size() - hb != 4) begin bad++; $display("FAIL timeout_attempts got=%0d want=4", hold_q.size() - hb); end
    for (int i = 0; i < 4; i++) begin
      h = (hb + i < hold_q.size()) ? hold_q[hb + i] : -1;
      total++; if (h != 16) begin bad++; $display("FAIL timeout_hold%0d got=%0d want=16", i, h); end
    end
    total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b want=0", seq_busy); end
    total++; if (uart_transmit !== 1'b0) begin bad++; $display("FAIL timeout_tx got=%b want=0", uart_transmit); end
    total++; if (seq_done !== 1'b0) begin bad++; $display("FAIL timeout_done got=%b want=0", seq_done); end
    total++; if (rx_q.size() != rb) begin bad++; $display("FAIL timeout_rx got=%0d want=%0d", rx_q.size(), rb); end
    ign_until = 0;
  endtask

  task automatic test_retry();
    int n, hb, rb, h;
    logic [7:0] got;
    ign_until = att_cnt + 1;
    hb = hold_q.size();
    rb = rx_q.size();
    result = 32'h11223344;
    make_exp(32'h11223344);
    pulse_run();
    total++; if (seq_error !== 1'b0) begin bad++; $display("FAIL retry_err_clr got=%b want=0", seq_error); end
    n = 0;
    while (seq_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++; if (seq_done !== 1'b1) begin bad++; $display("FAIL retry_done got=%b want=1", seq_done); end
    total++; if (seq_error !== 1'b0) begin bad++; $display("FAIL retry_error got=%b want=0", seq_error); end
    total++; if (hold_q.size() - hb != exp_n + 1) begin bad++; $display("FAIL retry_attempts got=%0d want=%0d", hold_q.size() - hb, exp_n + 1); end
    h = (hb < hold_q.size()) ? hold_q[hb] : -1;
    total++; if (h != 16) begin bad++; $display("FAIL retry_hold0 got=%0d want=16", h); end
    h = (hb + 1 < hold_q.size()) ? hold_q[hb + 1] : -1;
    total++; if (h != 2) begin bad++; $display("FAIL retry_hold1 got=%0d want=2", h); end
    for (int i = 0; i < exp_n; i++) begin
      got = (rb + i < rx_q.size()) ? rx_q[rb + i] : 8'hxx;
      total++; if (got !== exp_f[i]) begin bad++; $display("FAIL retry_frame%0d got=%h want=%h", i, got, exp_f[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n, rb;
    logic [7:0] got;
    rb = rx_q.size();
    result = 32'h11223344;
    make_exp(32'h11223344);
    pulse_run();
    n = 0;
    while (rx_q.size() < rb + 3 && n < 400) begin @(posedge clk); #1; n++; end
    total++; if (rx_q.size() < rb + 3) begin bad++; $display("FAIL mid_reach got=%0d want=%0d", rx_q.size() - rb, 3); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    total++; if (uart_transmit !== 1'b0) begin bad++; $display("FAIL mid_tx_same got=%b want=0", uart_transmit); end
    @(posedge clk); #1;
    total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", seq_busy); end
    total++; if (uart_transmit !== 1'b0) begin bad++; $display("FAIL mid_tx got=%b want=0", uart_transmit); end
    total++; if (uart_tx_byte !== 8'h00) begin bad++; $display("FAIL mid_byte got=%h want=00", uart_tx_byte); end
    reset = 1'b0;
    rb = rx_q.size();
    n = 0;
    while (seq_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++; if (rx_q.size() - rb != exp_n) begin bad++; $display("FAIL mid_count got=%0d want=%0d", rx_q.size() - rb, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      got = (rb + i < rx_q.size()) ? rx_q[rb + i] : 8'hxx;
      total++; if (got !== exp_f[i]) begin bad++; $display("FAIL mid_frame%0d got=%h want=%h", i, got, exp_f[i]); end
    end
  endtask

  task automatic test_vector();
    int n, rb, tn;
    logic [7:0] got;
    logic [7:0] tv [0:9];
`ifdef RESULT_UART_HEX_ASCII_EN
    tv = '{8'h30, 8'h41, 8'h31, 8'h42, 8'h32, 8'h43, 8'h33, 8'h44, 8'h0D, 8'h0A};
    tn = 10;
`else
    tv = '{8'h0A, 8'h1B, 8'h2C, 8'h3D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tn = 4;
`endif
    rb = rx_q.size();
    result = 32'h0A1B2C3D;
    pulse_run();
    n = 0;
    while (seq_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++; if (seq_done !== 1'b1) begin bad++; $display("FAIL vec_done got=%b want=1", seq_done); end
    total++; if (rx_q.size() - rb != tn) begin bad++; $display("FAIL vec_count got=%0d want=%0d", rx_q.size() - rb, tn); end
    for (int i = 0; i < tn; i++) begin
      got = (rb + i < rx_q.size()) ? rx_q[rb + i] : 8'hxx;
      total++; if (got !== tv[i]) begin bad++; $display("FAIL vec_frame%0d got=%h want=%h", i, got, tv[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rerun();
    test_timeout();
    test_retry();
    test_reset_mid();
    test_vector();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
